// File: rtl/sd_pcm_unpacker_pkg.sv
// Shared constants, FSM state type and divider helper for the SD PCM unpacker.
package sd_pcm_pkg;

  localparam int BYTES_PER_BLOCK   = 512;
  localparam int SAMPLES_PER_BLOCK = BYTES_PER_BLOCK / 2;
  localparam int SAMPLE_W          = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FILL = 2'd2
  } fill_state_e;

  // Integer floor of the clock-to-sample-rate ratio.
  function automatic int calc_div(input int clk_hz, input int sample_hz);
    return clk_hz / sample_hz;
  endfunction

endpackage

// File: rtl/sd_pcm_unpacker_fifo.sv
// Single-clock 16-bit sample FIFO with extra-MSB pointers; the popped head word
// is registered so it appears on the edge after pop_i (zero when popped empty).
module sd_sample_fifo
  import sd_pcm_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                push_i,
  input  logic [SAMPLE_W-1:0] push_data_i,
  input  logic                pop_i,
  output logic [SAMPLE_W-1:0] pop_data_o,
  output logic                full_o,
  output logic                empty_o,
  output logic [DEPTH_LOG2:0] level_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;

  logic [SAMPLE_W-1:0] mem_q [DEPTH];
  logic [SAMPLE_W-1:0] ram_q;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]       level_q, level_d;
  logic                zero_q, zero_d;
  logic                full, empty, do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                   (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
  assign do_pop  = pop_i && !empty;
  // A pop frees the slot this edge, so a push into a full FIFO still lands.
  assign do_push = push_i && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    level_d  = level_q + PW'(do_push) - PW'(do_pop);
    zero_d   = pop_i ? empty : zero_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      zero_q   <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      zero_q   <= zero_d;
    end
  end

  // Storage and read register carry no reset so they map onto block RAM.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= push_data_i;
    end
    if (do_pop) begin
      ram_q <= mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
    end
  end

  assign pop_data_o = zero_q ? '0 : ram_q;
  assign full_o     = full;
  assign empty_o    = empty;
  assign level_o    = level_q;

endmodule

// File: rtl/sd_pcm_unpacker.sv
// Pairs SD block bytes into little-endian PCM samples, buffers them and plays
// one sample per sample period while requesting blocks when a block fits.
module sd_pcm_unpacker
  import sd_pcm_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter int CLK_HZ     = 50000000,
  parameter int SAMPLE_HZ  = 44100
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic                byte_valid,
  input  logic [7:0]          byte_data,
  input  logic                block_done,
  output logic                block_req,
  output logic                sample_valid,
  output logic [15:0]         sample_out,
  output logic [DEPTH_LOG2:0] fifo_level,
  output logic                underrun,
  output logic                overflow,
  output logic                align_err,
  input  logic                clear_flags
);

  localparam int DIV   = calc_div(CLK_HZ, SAMPLE_HZ);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int LW    = DEPTH_LOG2 + 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [LW-1:0]    DEPTH_L   = LW'(1 << DEPTH_LOG2);
  localparam logic [LW-1:0]    BLOCK_L   = LW'(SAMPLES_PER_BLOCK);

  fill_state_e         state_q;
  logic                block_req_q;
  logic                phase_q, phase_d;
  logic [7:0]          low_q, low_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic                sample_valid_q;
  logic                underrun_q, underrun_d;
  logic                overflow_q, overflow_d;
  logic                align_q, align_d;

  logic                push, tick, align_set, underrun_set, overflow_set;
  logic [15:0]         push_data;
  logic                fifo_full, fifo_empty;
  logic [LW-1:0]       free_space;
  logic                room_for_block;

  // Byte pairing: a same-cycle byte is consumed before block_done clears phase.
  always_comb begin
    phase_d   = phase_q;
    low_d     = low_q;
    push      = 1'b0;
    align_set = 1'b0;
    if (byte_valid) begin
      if (phase_q) begin
        push = 1'b1;
      end else begin
        low_d = byte_data;
      end
      phase_d = ~phase_q;
    end else if (block_done && phase_q) begin
      align_set = 1'b1;
    end
    if (block_done) begin
      phase_d = 1'b0;
    end
  end

  assign push_data = {byte_data, low_q};

  // Sample period divider, parked at zero while paused.
  always_comb begin
    tick  = run && (div_q == DIV_LAST);
    div_d = div_q + DIV_W'(1);
    if (!run || tick) begin
      div_d = '0;
    end
  end

  // A full FIFO only accepts a push when the same edge pops.
  assign underrun_set = tick && fifo_empty;
  assign overflow_set = push && fifo_full && !tick;

  always_comb begin
    underrun_d = underrun_set | (underrun_q & ~clear_flags);
    overflow_d = overflow_set | (overflow_q & ~clear_flags);
    align_d    = align_set    | (align_q    & ~clear_flags);
  end

  assign free_space     = DEPTH_L - fifo_level;
  assign room_for_block = (free_space >= BLOCK_L);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      block_req_q <= 1'b0;
    end else begin
      block_req_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (run && room_for_block) begin
            state_q <= REQ;
          end
        end
        REQ: begin
          block_req_q <= 1'b1;
          state_q     <= FILL;
        end
        FILL: begin
          if (block_done) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q        <= 1'b0;
      low_q          <= '0;
      div_q          <= '0;
      sample_valid_q <= 1'b0;
      underrun_q     <= 1'b0;
      overflow_q     <= 1'b0;
      align_q        <= 1'b0;
    end else begin
      phase_q        <= phase_d;
      low_q          <= low_d;
      div_q          <= div_d;
      sample_valid_q <= tick;
      underrun_q     <= underrun_d;
      overflow_q     <= overflow_d;
      align_q        <= align_d;
    end
  end

  sd_sample_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk_i       (clk),
    .rst_ni      (rst),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (tick),
    .pop_data_o  (sample_out),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .level_o     (fifo_level)
  );

  assign block_req    = block_req_q;
  assign sample_valid = sample_valid_q;
  assign underrun     = underrun_q;
  assign overflow     = overflow_q;
  assign align_err    = align_q;

endmodule

// File: tb/tb_sd_pcm_unpacker.sv
// Randomized bench for sd_pcm_unpacker against a queue-based reference model.
module tb_sd_pcm_unpacker;

  localparam int DEPTH_LOG2 = 9;
  localparam int DEPTH      = 1 << DEPTH_LOG2;
  localparam int LW         = DEPTH_LOG2 + 1;
  localparam int DIV        = 10;

  logic          clk = 1'b0;
  logic          rst, run, byte_valid, block_done, clear_flags;
  logic [7:0]    byte_data;
  logic          block_req, sample_valid, underrun, overflow, align_err;
  logic [15:0]   sample_out;
  logic [LW-1:0] fifo_level;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] head_bytes [4];

  // Reference model state
  logic [15:0] m_q [$];
  logic [7:0]  m_low;
  bit          m_have_low;
  int          m_run_cycles;
  bit          m_valid;
  logic [15:0] m_out;
  bit          m_under, m_over, m_align;

  always #5 clk = ~clk;

  sd_pcm_unpacker #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .CLK_HZ     (1000),
    .SAMPLE_HZ  (100)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .run          (run),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .block_done   (block_done),
    .block_req    (block_req),
    .sample_valid (sample_valid),
    .sample_out   (sample_out),
    .fifo_level   (fifo_level),
    .underrun     (underrun),
    .overflow     (overflow),
    .align_err    (align_err),
    .clear_flags  (clear_flags)
  );

  task automatic model_reset();
    m_q.delete();
    m_low = '0; m_have_low = 0; m_run_cycles = 0;
    m_valid = 0; m_out = '0;
    m_under = 0; m_over = 0; m_align = 0;
  endtask

  // Applies the inputs seen at one rising edge to the behavioural model.
  task automatic model_edge();
    bit tick, have_sample, set_u, set_o, set_a;
    logic [15:0] smp;
    tick = 0; have_sample = 0; set_u = 0; set_o = 0; set_a = 0; smp = '0;
    if (!rst) begin
      model_reset();
      return;
    end
    if (run) begin
      m_run_cycles++;
      tick = (m_run_cycles % DIV) == 0;
    end else begin
      m_run_cycles = 0;
    end
    if (byte_valid) begin
      if (m_have_low) begin
        smp = {byte_data, m_low};
        have_sample = 1;
        m_have_low = 0;
      end else begin
        m_low = byte_data;
        m_have_low = 1;
      end
    end else if (block_done && m_have_low) begin
      set_a = 1;
    end
    if (block_done) m_have_low = 0;
    m_valid = tick;
    if (tick) begin
      if (m_q.size() > 0) m_out = m_q.pop_front();
      else begin m_out = '0; set_u = 1; end
    end
    if (have_sample) begin
      if (m_q.size() < DEPTH) m_q.push_back(smp);
      else set_o = 1;
    end
    m_under = set_u || (m_under && !clear_flags);
    m_over  = set_o || (m_over  && !clear_flags);
    m_align = set_a || (m_align && !clear_flags);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit done);
    byte_valid = 1; byte_data = b; block_done = done;
    step();
    byte_valid = 0; block_done = 0;
  endtask

  // Feeds nbytes with random idle gaps; returns how many block_req pulses were seen.
  task automatic feed_bytes(input int nbytes, input bit with_done, input bit head, output int reqs);
    bit done_sent;
    reqs = 0; done_sent = 0;
    for (int i = 0; i < nbytes; i++) begin
      while ($urandom_range(3) == 0) begin
        step(); reqs += int'(block_req);
      end
      byte_valid = 1;
      byte_data  = (head && i < 4) ? head_bytes[i] : 8'($urandom);
      block_done = with_done && (i == nbytes - 1) && ($urandom_range(1) == 1);
      done_sent  = block_done;
      step(); reqs += int'(block_req);
      byte_valid = 0; block_done = 0;
    end
    if (with_done && !done_sent) begin
      block_done = 1;
      step(); reqs += int'(block_req);
      block_done = 0;
    end
    $display("[TB] fed %0d bytes done=%0d level=%0d", nbytes, with_done, fifo_level);
  endtask

  task automatic pulse_reset();
    rst = 0;
    step(); step();
    rst = 1;
  endtask

  task automatic test_reset();
    rst = 0; run = 0; byte_valid = 0; byte_data = '0; block_done = 0; clear_flags = 0;
    step(); step();
    n_tests++;
    if ({block_req, sample_valid, sample_out, fifo_level, underrun, overflow, align_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h required 0",
               {block_req, sample_valid, sample_out, fifo_level, underrun, overflow, align_err});
    end
    rst = 1; run = 1;
    for (int c = 1; c <= 6; c++) begin
      step();
      n_tests++;
      if (block_req !== (c == 2)) begin
        n_fail++; $display("FAIL first_req cycle %0d: got %b required %b", c, block_req, (c == 2));
      end
      if (c == 2) run = 0;
    end
    $display("[TB] reset and first request checked");
  endtask

  task automatic test_first_block();
    int reqs;
    feed_bytes(512, 1, 1, reqs);
    n_tests++;
    if (fifo_level !== LW'(256) || reqs != 0) begin
      n_fail++; $display("FAIL block1_level: got level %0d reqs %0d required 256 and 0", fifo_level, reqs);
    end
    run = 1;
    for (int c = 1; c <= 2; c++) begin
      step();
      n_tests++;
      if (block_req !== (c == 2)) begin
        n_fail++; $display("FAIL second_req cycle %0d: got %b required %b", c, block_req, (c == 2));
      end
    end
    run = 0;
    feed_bytes(512, 1, 0, reqs);
    n_tests++;
    if (fifo_level !== LW'(512) || reqs != 0) begin
      n_fail++; $display("FAIL block2_level: got level %0d reqs %0d required 512 and 0", fifo_level, reqs);
    end
  endtask

  task automatic test_level_gating();
    int hit, nvalid;
    bit exp_req;
    hit = -1; nvalid = 0;
    run = 1;
    for (int c = 1; c < 4000; c++) begin
      step();
      exp_req = (hit >= 0) && (c == hit + 2);
      n_tests++;
      if (block_req !== exp_req) begin
        n_fail++; $display("FAIL gated_req cycle %0d: got %b required %b", c, block_req, exp_req);
      end
      n_tests++;
      if (sample_valid !== m_valid || (m_valid && sample_out !== m_out)) begin
        n_fail++; $display("FAIL gated_sample cycle %0d: got %b/%h required %b/%h",
                           c, sample_valid, sample_out, m_valid, m_out);
      end
      if (sample_valid) begin
        nvalid++;
        if (nvalid <= 2) begin
          n_tests++;
          if (sample_out !== ((nvalid == 1) ? 16'h1234 : 16'h5678)) begin
            n_fail++; $display("FAIL first_samples #%0d: got %h required %h",
                               nvalid, sample_out, (nvalid == 1) ? 16'h1234 : 16'h5678);
          end
          $display("[TB] sample #%0d = %h", nvalid, sample_out);
        end
      end
      if (hit < 0 && m_q.size() == 256) hit = c;
      if (hit >= 0 && c == hit + 3) break;
    end
    run = 0;
    n_tests++;
    if (hit < 0) begin
      n_fail++; $display("FAIL gated_timeout: got level %0d required drain to 256", fifo_level);
    end
  endtask

  task automatic test_overflow();
    int reqs;
    feed_bytes(512, 1, 0, reqs);
    n_tests++;
    if (fifo_level !== LW'(512) || overflow !== 1'b0) begin
      n_fail++; $display("FAIL ovf_fill: got level %0d ovf %b required 512 and 0", fifo_level, overflow);
    end
    feed_bytes(4, 0, 0, reqs);
    n_tests++;
    if (fifo_level !== LW'(512) || overflow !== 1'b1) begin
      n_fail++; $display("FAIL ovf_set: got level %0d ovf %b required 512 and 1", fifo_level, overflow);
    end
    clear_flags = 1; step(); clear_flags = 0;
    n_tests++;
    if (overflow !== 1'b0) begin
      n_fail++; $display("FAIL ovf_clear: got %b required 0", overflow);
    end
    run = 1;
    for (int c = 1; c <= 10; c++) begin
      byte_valid = (c == 5 || c == 10); byte_data = 8'($urandom);
      step();
      byte_valid = 0;
    end
    run = 0;
    n_tests++;
    if (sample_valid !== 1'b1 || fifo_level !== LW'(512) || overflow !== 1'b0 || sample_out !== m_out) begin
      n_fail++; $display("FAIL full_push_pop: got v%b lvl%0d ovf%b out%h required v1 lvl512 ovf0 out%h",
                         sample_valid, fifo_level, overflow, sample_out, m_out);
    end
  endtask

  task automatic test_underrun();
    pulse_reset();
    run = 1;
    for (int c = 1; c <= 32; c++) begin
      clear_flags = (c == 15);
      step();
      n_tests++;
      if (sample_valid !== m_valid || underrun !== m_under || (sample_valid && sample_out !== 16'h0)) begin
        n_fail++; $display("FAIL underrun cycle %0d: got v%b u%b out%h required v%b u%b out0000",
                           c, sample_valid, underrun, sample_out, m_valid, m_under);
      end
      if (c == 9 || c == 10 || c == 15 || c == 20) begin
        n_tests++;
        if (underrun !== (c == 10 || c == 20) || sample_valid !== (c == 10 || c == 20)) begin
          n_fail++; $display("FAIL underrun_point %0d: got u%b v%b required u%b v%b", c, underrun,
                             sample_valid, (c == 10 || c == 20), (c == 10 || c == 20));
        end
      end
    end
    clear_flags = 0; run = 0;
  endtask

  task automatic test_align();
    int nvalid;
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0);
    block_done = 1; step(); block_done = 0;
    n_tests++;
    if (align_err !== 1'b1 || fifo_level !== LW'(1)) begin
      n_fail++; $display("FAIL align_set: got err %b level %0d required 1 and 1", align_err, fifo_level);
    end
    send_byte(8'hCD, 0); send_byte(8'hAB, 0);
    send_byte(8'h5A, 0);
    block_done = 1; clear_flags = 1; step(); block_done = 0; clear_flags = 0;
    n_tests++;
    if (align_err !== 1'b1 || underrun !== 1'b0 || fifo_level !== LW'(2)) begin
      n_fail++; $display("FAIL align_set_wins: got err %b und %b lvl %0d required 1 0 2",
                         align_err, underrun, fifo_level);
    end
    run = 1; nvalid = 0;
    for (int c = 0; c < 40 && nvalid < 2; c++) begin
      step();
      if (sample_valid) begin
        nvalid++;
        n_tests++;
        if (sample_out !== ((nvalid == 1) ? 16'h2211 : 16'hABCD)) begin
          n_fail++; $display("FAIL align_sample #%0d: got %h required %h", nvalid, sample_out,
                             (nvalid == 1) ? 16'h2211 : 16'hABCD);
        end
        $display("[TB] aligned sample #%0d = %h", nvalid, sample_out);
      end
    end
    run = 0;
    n_tests++;
    if (nvalid != 2) begin
      n_fail++; $display("FAIL align_timeout: got %0d samples required 2", nvalid);
    end
  endtask

  task automatic test_pause();
    int r1, r2, bad;
    pulse_reset();
    run = 1;
    for (int c = 1; c <= 2; c++) begin
      step();
      n_tests++;
      if (block_req !== (c == 2)) begin
        n_fail++; $display("FAIL pause_req cycle %0d: got %b required %b", c, block_req, (c == 2));
      end
    end
    feed_bytes(300, 0, 0, r1);
    run = 0;
    feed_bytes(212, 1, 0, r2);
    n_tests++;
    if (fifo_level !== LW'(m_q.size()) || r1 + r2 != 0) begin
      n_fail++; $display("FAIL pause_fill: got lvl %0d reqs %0d required %0d and 0",
                         fifo_level, r1 + r2, m_q.size());
    end
    bad = 0;
    for (int c = 0; c < 60; c++) begin
      step();
      n_tests++;
      if (sample_valid !== 1'b0 || block_req !== 1'b0) begin
        n_fail++; $display("FAIL paused_quiet cycle %0d: got v%b req%b required 0 0", c, sample_valid, block_req);
      end
    end
  endtask

  task automatic test_async_reset();
    int reqs, nvalid;
    feed_bytes(101, 0, 0, reqs);
    #2 rst = 0;
    #1;
    n_tests++;
    if ({block_req, sample_valid, sample_out, fifo_level, underrun, overflow, align_err} !== '0) begin
      n_fail++; $display("FAIL async_reset: got %h required 0",
                         {block_req, sample_valid, sample_out, fifo_level, underrun, overflow, align_err});
    end
    step(); step();
    rst = 1; run = 1;
    for (int c = 1; c <= 4; c++) begin
      step();
      n_tests++;
      if (block_req !== (c == 2)) begin
        n_fail++; $display("FAIL rereset_req cycle %0d: got %b required %b", c, block_req, (c == 2));
      end
    end
    run = 0;
    send_byte(8'hCD, 0); send_byte(8'hAB, 0);
    run = 1; nvalid = 0;
    for (int c = 0; c < 20 && nvalid == 0; c++) begin
      step();
      if (sample_valid) begin
        nvalid++;
        n_tests++;
        if (sample_out !== 16'hABCD) begin
          n_fail++; $display("FAIL rereset_phase: got %h required abcd", sample_out);
        end
      end
    end
    run = 0;
    n_tests++;
    if (nvalid != 1) begin
      n_fail++; $display("FAIL rereset_timeout: got %0d samples required 1", nvalid);
    end
  endtask

  task automatic test_random_traffic();
    int prob;
    run = 1;
    for (int c = 0; c < 3000; c++) begin
      prob = (c < 800) ? 10 : (c < 2600) ? 90 : 15;
      byte_valid  = ($urandom_range(99) < prob);
      byte_data   = 8'($urandom);
      block_done  = ($urandom_range(199) == 0);
      clear_flags = ($urandom_range(49) == 0);
      if ($urandom_range(299) == 0) run = ~run;
      step();
      n_tests++;
      if ({sample_valid, sample_out, fifo_level, underrun, overflow, align_err} !==
          {m_valid, m_out, LW'(m_q.size()), m_under, m_over, m_align}) begin
        n_fail++;
        $display("FAIL random cycle %0d: got v%b out%h lvl%0d u%b o%b a%b required v%b out%h lvl%0d u%b o%b a%b",
                 c, sample_valid, sample_out, fifo_level, underrun, overflow, align_err,
                 m_valid, m_out, m_q.size(), m_under, m_over, m_align);
      end
    end
    byte_valid = 0; block_done = 0; clear_flags = 0; run = 0;
    $display("[TB] random traffic done, level=%0d", fifo_level);
  endtask

  initial begin
    head_bytes = '{8'h34, 8'h12, 8'h78, 8'h56};
    model_reset();
    test_reset();
    test_first_block();
    test_level_gating();
    test_overflow();
    test_underrun();
    test_align();
    test_pause();
    test_async_reset();
    test_random_traffic();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion required finish before 2 ms");
    $fatal(1, "watchdog expired");
  end

endmodule
